// File: rtl/fetch_inst_buffer_pkg.sv
// Shared core definitions for the fetch/decode boundary. Holds the fetch
// entry type, the default fetch/decode widths and the slot-mask helpers
// (popcount, leading ones) used by the instruction buffer.
package fetch_inst_buffer_pkg;

    // Default number of fetch slots delivered per cycle
    localparam int FETCH_WIDTH  = 4;
    // Default number of decode slots consumed per cycle
    localparam int DECODE_WIDTH = 4;
    // Widest slot mask the helpers accept; callers zero-extend narrower masks
    localparam int MAX_SLOTS    = 16;

    // One fetched instruction as it travels from fetch to decode
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        has_except;
    } fetchEntry_t;

    typedef logic [MAX_SLOTS-1:0] slot_mask_t;

    // Number of set bits in a slot mask
    function automatic logic [7:0] popcount(input slot_mask_t v);
        logic [7:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            cnt = cnt + 8'(v[i]);
        end
        return cnt;
    endfunction

    // Length of the unbroken run of ones starting at slot 0
    function automatic logic [7:0] leading_ones(input slot_mask_t v);
        logic [7:0] cnt;
        logic       run;
        cnt = '0;
        run = 1'b1;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            run = run & v[i];
            cnt = cnt + 8'(run);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/fetch_inst_buffer.sv
// Fetch-to-decode instruction buffer: a circular FIFO that accepts up to
// ENQ_WIDTH contiguous fetch slots per cycle and presents up to DEQ_WIDTH of
// its oldest entries to decode. A group presented to decode ends at the first
// excepting entry, so an exception always travels as the last slot of a group.
// Head and tail carry one extra wrap bit so full and empty are distinct.
module fetch_inst_buffer
    import fetch_inst_buffer_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ENQ_WIDTH = FETCH_WIDTH,
    parameter int DEQ_WIDTH = DECODE_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ENQ_WIDTH-1:0]          i_enq_vld,
    input  fetchEntry_t [ENQ_WIDTH-1:0]   i_enq_inst,
    output logic                          o_can_enq,
    output logic [DEQ_WIDTH-1:0]          o_deq_vld,
    output fetchEntry_t [DEQ_WIDTH-1:0]   o_deq_inst,
    input  logic                          i_deq_rdy,
    input  logic                          i_squash_vld,
    output logic [$clog2(DEPTH):0]        o_count
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ENQ_CNT   = (AW+1)'(ENQ_WIDTH);

    fetchEntry_t    mem [DEPTH];

    logic [AW:0]    head;
    logic [AW:0]    tail;
    logic [AW:0]    nenq;
    logic [AW:0]    ndeq;
    logic           enq_fire;
    logic [AW-1:0]  wr_idx [ENQ_WIDTH];
    logic [AW-1:0]  rd_idx [DEQ_WIDTH];
    logic [DEQ_WIDTH-1:0] deq_ok;
    logic [7:0]     n_ok;

    // Occupancy falls out of the wrap-bit pointers; subtraction wraps mod 2*DEPTH
    assign o_count = tail - head;

    // Space check uses registered occupancy only, never same-cycle dequeue
    assign o_can_enq = (DEPTH_CNT - o_count) >= ENQ_CNT;

    // Present the oldest DEQ_WIDTH entries straight from storage
    always_comb begin
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            rd_idx[i]     = head[AW-1:0] + AW'(i);
            o_deq_inst[i] = mem[rd_idx[i]];
        end
    end

    // Slot i is deliverable if occupied and nothing older in the group excepts
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and infers a latch.
        deq_ok    = '0;
        o_deq_vld = '0;
        deq_ok[0] = (o_count != '0);
        for (int i = 1; i < DEQ_WIDTH; i++) begin
            deq_ok[i] = ((AW+1)'(i) < o_count) && !o_deq_inst[i-1].has_except;
        end
        n_ok = leading_ones(slot_mask_t'(deq_ok));
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            o_deq_vld[i] = (8'(i) < n_ok);
        end
    end

    // Per-cycle enqueue/dequeue amounts and write slots
    always_comb begin
        nenq     = (AW+1)'(popcount(slot_mask_t'(i_enq_vld)));
        ndeq     = (AW+1)'(popcount(slot_mask_t'(o_deq_vld)));
        enq_fire = o_can_enq && (|i_enq_vld);
        for (int k = 0; k < ENQ_WIDTH; k++) begin
            wr_idx[k] = tail[AW-1:0] + AW'(k);
        end
    end

    // Pointer update: reset beats squash, squash beats enqueue/dequeue
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else if (i_squash_vld) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (enq_fire) begin
                tail <= tail + nenq;
            end
            if (i_deq_rdy) begin
                head <= head + ndeq;
            end
        end
    end

    // Payload write in slot order at tail..tail+n-1
    always_ff @(posedge clk) begin
        // NOTE: payload storage is deliberately not reset; the pointers alone decide which entries are live.
        if (!rst && !i_squash_vld && enq_fire) begin
            for (int k = 0; k < ENQ_WIDTH; k++) begin
                if (i_enq_vld[k]) begin
                    mem[wr_idx[k]] <= i_enq_inst[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Self-checking bench for fetch_inst_buffer: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_fetch_inst_buffer;
    import fetch_inst_buffer_pkg::*;

    localparam int DEPTH = 16;
    localparam int ENQ   = 4;
    localparam int DEQ   = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [ENQ-1:0]          enq_vld;
    fetchEntry_t [ENQ-1:0]   enq_inst;
    logic                    can_enq;
    logic [DEQ-1:0]          deq_vld;
    fetchEntry_t [DEQ-1:0]   deq_inst;
    logic                    deq_rdy;
    logic                    squash;
    logic [4:0]              count;

    int n_checks = 0;
    int n_errors = 0;
    int serial   = 0;

    fetchEntry_t model_q[$];

    fetch_inst_buffer #(.DEPTH(DEPTH), .ENQ_WIDTH(ENQ), .DEQ_WIDTH(DEQ)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_enq_vld    (enq_vld),
        .i_enq_inst   (enq_inst),
        .o_can_enq    (can_enq),
        .o_deq_vld    (deq_vld),
        .o_deq_inst   (deq_inst),
        .i_deq_rdy    (deq_rdy),
        .i_squash_vld (squash),
        .o_count      (count)
    );

    always #5 clk = ~clk;

    // Fetch must only ever present contiguous valid slots starting at slot 0
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            assert ((enq_vld & (enq_vld + 4'd1)) == '0)
                else $error("illegal non-contiguous enqueue valid %b", enq_vld);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic fetchEntry_t make_entry(input logic exc);
        fetchEntry_t e;
        e.pc         = 32'(serial * 4);
        e.inst       = $urandom;
        e.has_except = exc;
        serial++;
        return e;
    endfunction

    // Reference: oldest entries up to DEQ, ending at (and including) the first exception
    function automatic int model_ndeq();
        int n = 0;
        while (n < DEQ && n < model_q.size()) begin
            n++;
            if (model_q[n-1].has_except) break;
        end
        return n;
    endfunction

    task automatic drive(input int n, input logic [ENQ-1:0] exc, input logic rdy,
                         input logic sq, input logic r);
        for (int k = 0; k < ENQ; k++) begin
            enq_vld[k] = (k < n);
            enq_inst[k] = (k < n) ? make_entry(exc[k]) : '0;
        end
        deq_rdy = rdy;
        squash  = sq;
        rst     = r;
    endtask

    // Advance one clock and move the reference model by the same rules
    task automatic tick();
        int nd;
        bit can;
        nd  = model_ndeq();
        can = (DEPTH - model_q.size()) >= ENQ;
        @(posedge clk);
        if (rst || squash) begin
            model_q.delete();
        end else begin
            if (deq_rdy) for (int k = 0; k < nd; k++) void'(model_q.pop_front());
            if (can) for (int k = 0; k < ENQ; k++) if (enq_vld[k]) model_q.push_back(enq_inst[k]);
        end
        #1;
    endtask

    task automatic do_reset();
        drive(0, '0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        drive(4, '0, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (deq_vld !== 4'b0000) begin n_errors++; $display("FAIL reset_vld: got %b expected 0000", deq_vld); end
        n_checks++; if (can_enq !== 1'b1) begin n_errors++; $display("FAIL reset_can_enq: got %b expected 1", can_enq); end
        drive(0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++; if (count !== 5'd0 || deq_vld !== 4'b0000 || can_enq !== 1'b1) begin
            n_errors++; $display("FAIL after_reset: count %0d vld %b can %b expected 0 0000 1", count, deq_vld, can_enq);
        end
    endtask

    task automatic test_first_enq();
        fetchEntry_t first;
        do_reset();
        drive(4, '0, 1'b0, 1'b0, 1'b0);
        first = enq_inst[0];
        n_checks++; if (deq_vld !== 4'b0000) begin n_errors++; $display("FAIL no_bypass_vld: got %b expected 0000", deq_vld); end
        tick();
        drive(0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (count !== 5'd4) begin n_errors++; $display("FAIL first_count: got %0d expected 4", count); end
        n_checks++; if (deq_vld !== 4'b1111) begin n_errors++; $display("FAIL first_vld: got %b expected 1111", deq_vld); end
        n_checks++; if (deq_inst[0] !== first) begin n_errors++; $display("FAIL first_slot0: got %h expected %h", deq_inst[0], first); end
    endtask

    task automatic test_fill();
        logic [31:0] base = '0;
        do_reset();
        for (int g = 1; g <= 5; g++) begin
            drive(4, '0, 1'b0, 1'b0, 1'b0);
            if (g == 1) base = enq_inst[0].pc;
            tick();
            if (g == 3) begin
                n_checks++; if (count !== 5'd12 || can_enq !== 1'b1) begin n_errors++; $display("FAIL fill3: count %0d can %b expected 12 1", count, can_enq); end
            end
            if (g >= 4) begin
                n_checks++; if (count !== 5'd16 || can_enq !== 1'b0) begin n_errors++; $display("FAIL fill%0d: count %0d can %b expected 16 0", g, count, can_enq); end
            end
        end
        for (int c = 0; c < 4; c++) begin
            drive(0, '0, 1'b1, 1'b0, 1'b0);
            n_checks++; if (deq_vld !== 4'b1111) begin n_errors++; $display("FAIL drain_vld c%0d: got %b expected 1111", c, deq_vld); end
            for (int i = 0; i < DEQ; i++) begin
                n_checks++;
                if (deq_inst[i].pc !== base + 32'(4 * (4 * c + i))) begin
                    n_errors++; $display("FAIL drain_pc c%0d s%0d: got %h expected %h", c, i, deq_inst[i].pc, base + 32'(4 * (4 * c + i)));
                end
            end
            tick();
        end
        n_checks++; if (count !== 5'd0 || can_enq !== 1'b1 || deq_vld !== 4'b0000) begin
            n_errors++; $display("FAIL drained: count %0d can %b vld %b expected 0 1 0000", count, can_enq, deq_vld);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] base;
        do_reset();
        drive(2, '0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(0, '0, 1'b1, 1'b0, 1'b0);
        tick();
        n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL stream_pre: got %0d expected 0", count); end
        drive(4, '0, 1'b0, 1'b0, 1'b0);
        base = enq_inst[0].pc;
        tick();
        for (int c = 0; c < 10; c++) begin
            drive(4, '0, 1'b1, 1'b0, 1'b0);
            n_checks++; if (count !== 5'd4) begin n_errors++; $display("FAIL stream_count c%0d: got %0d expected 4", c, count); end
            n_checks++; if (deq_vld !== 4'b1111) begin n_errors++; $display("FAIL stream_vld c%0d: got %b expected 1111", c, deq_vld); end
            for (int i = 0; i < DEQ; i++) begin
                n_checks++;
                if (deq_inst[i].pc !== base + 32'(4 * (4 * c + i))) begin
                    n_errors++; $display("FAIL stream_pc c%0d s%0d: got %h expected %h", c, i, deq_inst[i].pc, base + 32'(4 * (4 * c + i)));
                end
            end
            tick();
        end
        drive(0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (count !== 5'd4) begin n_errors++; $display("FAIL stream_end: got %0d expected 4", count); end
    endtask

    task automatic test_except();
        logic [31:0] base;
        do_reset();
        drive(4, 4'b0010, 1'b0, 1'b0, 1'b0);
        base = enq_inst[0].pc;
        tick();
        drive(0, '0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (deq_vld !== 4'b0011) begin n_errors++; $display("FAIL except_vld: got %b expected 0011", deq_vld); end
        tick();
        drive(0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (count !== 5'd2) begin n_errors++; $display("FAIL except_count: got %0d expected 2", count); end
        n_checks++; if (deq_vld !== 4'b0011) begin n_errors++; $display("FAIL except_rest_vld: got %b expected 0011", deq_vld); end
        n_checks++; if (deq_inst[0].pc !== base + 32'd8) begin n_errors++; $display("FAIL except_head: got %h expected %h", deq_inst[0].pc, base + 32'd8); end
    endtask

    task automatic test_squash();
        do_reset();
        drive(4, '0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(4, '0, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++; if (count !== 5'd8) begin n_errors++; $display("FAIL squash_pre: got %0d expected 8", count); end
        drive(4, '0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (count !== 5'd0 || deq_vld !== 4'b0000 || can_enq !== 1'b1) begin
            n_errors++; $display("FAIL squash: count %0d vld %b can %b expected 0 0000 1", count, deq_vld, can_enq);
        end
        drive(4, '0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(4, '0, 1'b1, 1'b0, 1'b1);
        tick();
        drive(0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (count !== 5'd0 || deq_vld !== 4'b0000) begin
            n_errors++; $display("FAIL midop_reset: count %0d vld %b expected 0 0000", count, deq_vld);
        end
    endtask

    task automatic test_random();
        int nd;
        logic [DEQ-1:0] exp_vld;
        logic exp_can;
        logic [ENQ-1:0] exc;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < ENQ; k++) exc[k] = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 4), exc,
                  ((cyc / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 99) == 0), ($urandom_range(0, 299) == 0));
            nd      = model_ndeq();
            exp_vld = DEQ'((1 << nd) - 1);
            exp_can = ((DEPTH - model_q.size()) >= ENQ);
            n_checks++; if (count !== 5'(model_q.size())) begin n_errors++; $display("FAIL rand_count cyc%0d: got %0d expected %0d", cyc, count, model_q.size()); end
            n_checks++; if (can_enq !== exp_can) begin n_errors++; $display("FAIL rand_can cyc%0d: got %b expected %b", cyc, can_enq, exp_can); end
            n_checks++; if (deq_vld !== exp_vld) begin n_errors++; $display("FAIL rand_vld cyc%0d: got %b expected %b", cyc, deq_vld, exp_vld); end
            for (int i = 0; i < nd; i++) begin
                n_checks++;
                if (deq_inst[i] !== model_q[i]) begin
                    n_errors++; $display("FAIL rand_slot cyc%0d s%0d: got %h expected %h", cyc, i, deq_inst[i], model_q[i]);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst     = 1'b1;
        enq_vld = '0;
        enq_inst = '0;
        deq_rdy = 1'b0;
        squash  = 1'b0;
        test_reset();
        test_first_enq();
        test_fill();
        test_back_to_back();
        test_except();
        test_squash();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
